// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared constants and types for the elastic pipeline register.
//                NOP_INST is the RISC-V canonical NOP (addi x0,x0,0), and it
//                is the payload shown whenever a stage holds no instruction.
//                Default widths and the 2-bit occupancy type are also here.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  localparam int          DATA_W_DEF = 32;
  localparam int          CTRL_W_DEF = 12;
  localparam int          CNT_W_DEF  = 16;

  // Occupancy of the register: 0, 1 or 2 entries.
  typedef logic [1:0] occ_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_sat_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_sat_cnt
//  Description : Saturating accumulator. When i_en is high, i_inc is added
//                on the rising edge. The count stops at all-ones and never
//                wraps.
//  Ports       : i_clk   - clock
//                i_reset - asynchronous active-high reset (count -> 0)
//                i_en    - add enable
//                i_inc   - increment amount (INC_W bits, INC_W <= CNT_W)
//                o_cnt   - current count (CNT_W bits)
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_sat_cnt #(
  parameter int CNT_W = 16,
  parameter int INC_W = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [INC_W-1:0] i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W:0]   sum;

  always_comb begin
    // One extra bit catches the carry out, which means the sum overflowed.
    sum   = {1'b0, cnt_q} + (CNT_W+1)'(i_inc);
    cnt_d = cnt_q;
    if (i_en) begin
      cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule : pipe_sat_cnt
`default_nettype wire

// File: rtl/pipe_reg_elastic.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_reg_elastic
//  Description : Elastic pipeline register with valid/ready handshake, stall,
//                flush and a saturating flush-drop counter.
//                Configuration macro: PIPE_REG_SKID_EN
//                  defined   -> two slots (output + skid). o_ready is a
//                               registered "skid empty" flag, so there is no
//                               combinational path from i_ready to o_ready.
//                  undefined -> one slot. o_ready is combinational:
//                               (!o_valid | i_ready) & !i_stall & !i_reset.
//  Ports       : i_clk, i_reset (async, active-high), i_flush, i_stall
//                i_valid/o_ready/i_data/i_ctrl  - upstream side
//                o_valid/i_ready/o_data/o_ctrl  - downstream side
//                o_count    - entries held (0..2)
//                o_drop_cnt - held entries discarded by flush (saturating)
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg_elastic
  import pipe_pkg::*;
#(
  parameter int                 DATA_W   = DATA_W_DEF,
  parameter int                 CTRL_W   = CTRL_W_DEF,
  parameter logic [DATA_W-1:0]  NOP_DATA = DATA_W'(NOP_INST),
  parameter int                 CNT_W    = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_stall,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [1:0]        o_count,
  output logic [CNT_W-1:0]  o_drop_cnt
);

  logic              out_vld_q,  out_vld_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
  logic              accept;
  logic              pop;
  occ_t              count;

  // A stall hides the output entry from downstream. The payload stays
  // visible so the held value can still be observed.
  assign o_valid = out_vld_q & ~i_stall;
  assign pop     = o_valid & i_ready;
  assign accept  = i_valid & o_ready & ~i_stall & ~i_flush;
  assign o_data  = out_vld_q ? out_data_q : NOP_DATA;
  assign o_ctrl  = out_vld_q ? out_ctrl_q : '0;
  assign o_count = count;

`ifdef PIPE_REG_SKID_EN
  logic              skid_vld_q,  skid_vld_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              rdy_q,       rdy_d;

  // rdy_q resets low, so o_ready rises on the first edge after reset release.
  assign o_ready = rdy_q & ~i_stall;
  assign count   = occ_t'(out_vld_q) + occ_t'(skid_vld_q);

  always_comb begin
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    out_ctrl_d  = out_ctrl_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    rdy_d       = rdy_q;
    if (i_flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
      rdy_d      = 1'b1;
    end else if (!i_stall) begin
      if (!out_vld_q || pop) begin
        if (skid_vld_q) begin
          // The older skid entry moves forward first to keep FIFO order.
          // A new entry accepted in the same cycle refills the skid slot.
          out_vld_d  = 1'b1;
          out_data_d = skid_data_q;
          out_ctrl_d = skid_ctrl_q;
          skid_vld_d = accept;
          if (accept) begin
            skid_data_d = i_data;
            skid_ctrl_d = i_ctrl;
          end
        end else begin
          out_vld_d = accept;
          if (accept) begin
            out_data_d = i_data;
            out_ctrl_d = i_ctrl;
          end
        end
      end else if (accept) begin
        skid_vld_d  = 1'b1;
        skid_data_d = i_data;
        skid_ctrl_d = i_ctrl;
      end
      rdy_d = ~skid_vld_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_ctrl_q  <= '0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      rdy_q       <= 1'b0;
    end else begin
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_ctrl_q  <= out_ctrl_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      rdy_q       <= rdy_d;
    end
  end
`else
  assign o_ready = (~o_valid | i_ready) & ~i_stall & ~i_reset;
  assign count   = occ_t'(out_vld_q);

  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_ctrl_d = out_ctrl_q;
    if (i_flush) begin
      out_vld_d = 1'b0;
    end else if (!i_stall && (!out_vld_q || pop)) begin
      out_vld_d = accept;
      if (accept) begin
        out_data_d = i_data;
        out_ctrl_d = i_ctrl;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_ctrl_q <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_ctrl_q <= out_ctrl_d;
    end
  end
`endif

  // A flush discards exactly the entries held before the edge.
  pipe_sat_cnt #(
    .CNT_W (CNT_W),
    .INC_W (2)
  ) u_drop_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (i_flush),
    .i_inc   (count),
    .o_cnt   (o_drop_cnt)
  );

endmodule : pipe_reg_elastic
`default_nettype wire
